// File: rtl/tpu_result_unloader_if.sv
// Handshake bundle for tpu_result_unloader: burst control, TPU RAM read port and host stream.
// slave is the unloader's view; master is the controller / RAM / host side.
interface tpu_result_unloader_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 6
);
   logic                  rd_start;
   logic [ADDR_WIDTH-1:0] rd_base;
   logic [ADDR_WIDTH:0]   rd_len;
   logic                  busy;
   logic                  done;
   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_rd_addr;
   logic [DATA_WIDTH-1:0] mem_rd_data;
   logic [DATA_WIDTH-1:0] host_data;
   logic                  host_valid;
   logic                  host_ready;

   modport slave (
      input  rd_start, rd_base, rd_len, mem_rd_data, host_ready,
      output busy, done, mem_rd_en, mem_rd_addr, host_data, host_valid
   );

   modport master (
      output rd_start, rd_base, rd_len, mem_rd_data, host_ready,
      input  busy, done, mem_rd_en, mem_rd_addr, host_data, host_valid
   );
endinterface

// File: rtl/tpu_result_unloader.sv
// Burst reader: moves rd_len words from TPU RAM to the host one at a time (READ/CAPTURE/OUT).
// Optional running checksum of delivered words is enabled by defining UNLOADER_CHECKSUM_EN.
module tpu_result_unloader #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   tpu_result_unloader_if.slave  bus
`ifdef UNLOADER_CHECKSUM_EN
   ,
   output logic [15:0]           checksum
`endif
);

   typedef enum logic [2:0] {StIdle, StRead, StCapture, StOut, StFin} state_e;

   localparam logic [ADDR_WIDTH:0]   RemOne  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

   state_e                state_q, state_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  mem_rd_en_q, mem_rd_en_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   rem_q, rem_d;
   logic [DATA_WIDTH-1:0] host_data_q, host_data_d;
   logic                  host_valid_q, host_valid_d;
`ifdef UNLOADER_CHECKSUM_EN
   logic [15:0]           sum_q, sum_d;
`endif

   always_comb begin
      state_d      = state_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      mem_rd_en_d  = 1'b0;
      addr_d       = addr_q;
      rem_d        = rem_q;
      host_data_d  = host_data_q;
      host_valid_d = host_valid_q;
`ifdef UNLOADER_CHECKSUM_EN
      sum_d        = sum_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (bus.rd_start) begin
               busy_d = 1'b1;
`ifdef UNLOADER_CHECKSUM_EN
               sum_d  = '0;
`endif
               if (bus.rd_len != '0) begin
                  addr_d      = bus.rd_base;
                  rem_d       = bus.rd_len;
                  mem_rd_en_d = 1'b1;
                  state_d     = StRead;
               end else begin
                  // Empty burst: report completion without touching the RAM.
                  done_d  = 1'b1;
                  state_d = StFin;
               end
            end
         end
         StRead: state_d = StCapture;
         StCapture: begin
            host_data_d  = bus.mem_rd_data;
            host_valid_d = 1'b1;
            state_d      = StOut;
         end
         StOut: begin
            if (host_valid_q && bus.host_ready) begin
               host_valid_d = 1'b0;
               addr_d       = addr_q + AddrOne;
               rem_d        = rem_q - RemOne;
`ifdef UNLOADER_CHECKSUM_EN
               sum_d        = sum_q + 16'(host_data_q);
`endif
               if (rem_q == RemOne) begin
                  done_d  = 1'b1;
                  state_d = StFin;
               end else begin
                  mem_rd_en_d = 1'b1;
                  state_d     = StRead;
               end
            end
         end
         StFin: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         mem_rd_en_q  <= 1'b0;
         addr_q       <= '0;
         rem_q        <= '0;
         host_data_q  <= '0;
         host_valid_q <= 1'b0;
`ifdef UNLOADER_CHECKSUM_EN
         sum_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         mem_rd_en_q  <= mem_rd_en_d;
         addr_q       <= addr_d;
         rem_q        <= rem_d;
         host_data_q  <= host_data_d;
         host_valid_q <= host_valid_d;
`ifdef UNLOADER_CHECKSUM_EN
         sum_q        <= sum_d;
`endif
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.mem_rd_en   = mem_rd_en_q;
   assign bus.mem_rd_addr = addr_q;
   assign bus.host_data   = host_data_q;
   assign bus.host_valid  = host_valid_q;
`ifdef UNLOADER_CHECKSUM_EN
   assign checksum        = sum_q;
`endif

endmodule

// File: tb/tb_tpu_result_unloader.sv
// Directed bench for tpu_result_unloader: small RAM model, negedge monitor logging reads,
// transfers and done pulses, and assertion-based checks against hand-computed values.
module tb_tpu_result_unloader;
   localparam int unsigned DW = 8;
   localparam int unsigned AW = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   tpu_result_unloader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
`ifdef UNLOADER_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   tpu_result_unloader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
`ifdef UNLOADER_CHECKSUM_EN
      ,
      .checksum (checksum)
`endif
   );

   logic [7:0] ram [64];
   always @(posedge clk) if (bus.mem_rd_en === 1'b1) bus.mem_rd_data <= ram[bus.mem_rd_addr];

   int cyc = 0, addr_n = 0, hv_n = 0, done_n = 0, word_n = 0, last_xfer_cyc = 0, done_cyc = 0;
   logic [7:0] word_log [256];
   logic [5:0] addr_log [256];
   int total = 0, bad = 0;
   logic [7:0] ew [4];
   logic [5:0] ea [4];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.mem_rd_en === 1'b1) begin
         addr_log[8'(addr_n)] <= bus.mem_rd_addr;
         addr_n <= addr_n + 1;
      end
      if (bus.host_valid === 1'b1) hv_n <= hv_n + 1;
      if (bus.host_valid === 1'b1 && bus.host_ready === 1'b1) begin
         word_log[8'(word_n)] <= bus.host_data;
         word_n <= word_n + 1;
         last_xfer_cyc <= cyc;
      end
      if (bus.done === 1'b1) begin
         done_n <= done_n + 1;
         done_cyc <= cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [5:0] base, input logic [6:0] len);
      bus.rd_start = 1'b1;
      bus.rd_base  = base;
      bus.rd_len   = len;
      step();
      bus.rd_start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.host_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic check_run(input string tag, input int w0, input int a0, input int n);
      chk({tag, "_nwords"}, 32'(word_n - w0), 32'(n));
      chk({tag, "_nreads"}, 32'(addr_n - a0), 32'(n));
      for (int i = 0; i < n; i++) begin
         chk({tag, "_word"}, 32'(word_log[8'(w0 + i)]), 32'(ew[i]));
         chk({tag, "_addr"}, 32'(addr_log[8'(a0 + i)]), 32'(ea[i]));
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"},  32'(bus.busy), 32'd0);
      chk({tag, "_done"},  32'(bus.done), 32'd0);
      chk({tag, "_rden"},  32'(bus.mem_rd_en), 32'd0);
      chk({tag, "_addr"},  32'(bus.mem_rd_addr), 32'd0);
      chk({tag, "_data"},  32'(bus.host_data), 32'd0);
      chk({tag, "_valid"}, 32'(bus.host_valid), 32'd0);
`ifdef UNLOADER_CHECKSUM_EN
      chk({tag, "_csum"},  32'(checksum), 32'd0);
`endif
   endtask

   initial begin
      bit ok;
      int w0, a0, d0, s0, hv0, en_mid;
      bus.rd_start = 1'b0;
      bus.rd_base = '0;
      bus.rd_len = '0;
      bus.host_ready = 1'b0;
      for (int i = 0; i < 64; i++) ram[i] = 8'(i + 8'h40);

      // Reset values
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      #1 rst_n = 1'b1;

      // Four identical words, host always ready
      ram[0] = 8'h03; ram[1] = 8'h03; ram[2] = 8'h03; ram[3] = 8'h03;
      ew = '{8'h03, 8'h03, 8'h03, 8'h03};
      ea = '{6'd0, 6'd1, 6'd2, 6'd3};
      bus.host_ready = 1'b1;
      w0 = word_n; a0 = addr_n; d0 = done_n;
      start(6'd0, 7'd4);
      s0 = cyc;
      chk("basic_busy_after_start", 32'(bus.busy), 32'd1);
      wait_done(40, ok);
      chk("basic_done_seen", 32'(ok), 32'd1);
      chk("basic_busy_in_fin", 32'(bus.busy), 32'd1);
      chk("basic_valid_in_fin", 32'(bus.host_valid), 32'd0);
      @(negedge clk);
      chk("basic_busy_after_fin", 32'(bus.busy), 32'd0);
      chk("basic_done_one_cycle", 32'(bus.done), 32'd0);
      check_run("basic", w0, a0, 4);
      chk("basic_latency", 32'(done_cyc - s0), 32'd12);
      chk("basic_done_after_xfer", 32'(done_cyc - last_xfer_cyc), 32'd1);
      chk("basic_done_pulses", 32'(done_n - d0), 32'd1);
`ifdef UNLOADER_CHECKSUM_EN
      chk("basic_csum", 32'(checksum), 32'h000C);
`endif

      // Address wrap 62,63,0,1
      ram[62] = 8'hAA; ram[63] = 8'hBB; ram[0] = 8'h11; ram[1] = 8'h22;
      ew = '{8'hAA, 8'hBB, 8'h11, 8'h22};
      ea = '{6'd62, 6'd63, 6'd0, 6'd1};
      w0 = word_n; a0 = addr_n;
      start(6'd62, 7'd4);
      wait_done(40, ok);
      chk("wrap_done_seen", 32'(ok), 32'd1);
      @(negedge clk);
      check_run("wrap", w0, a0, 4);
`ifdef UNLOADER_CHECKSUM_EN
      chk("wrap_csum", 32'(checksum), 32'h0198);
`endif

      // Host back-pressure for five cycles on word 2
      ram[0] = 8'h01; ram[1] = 8'h02; ram[2] = 8'h03; ram[3] = 8'h04;
      ew = '{8'h01, 8'h02, 8'h03, 8'h04};
      ea = '{6'd0, 6'd1, 6'd2, 6'd3};
      bus.host_ready = 1'b0;
      w0 = word_n; a0 = addr_n;
      start(6'd0, 7'd4);
      wait_valid(20, ok);
      chk("stall_w1_valid", 32'(ok), 32'd1);
      step();
      bus.host_ready = 1'b1;
      step();
      bus.host_ready = 1'b0;
      wait_valid(20, ok);
      chk("stall_w2_valid", 32'(ok), 32'd1);
      en_mid = addr_n;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid_held", 32'(bus.host_valid), 32'd1);
         chk("stall_data_held", 32'(bus.host_data), 32'h02);
      end
      chk("stall_no_extra_read", 32'(addr_n - en_mid), 32'd0);
      step();
      bus.host_ready = 1'b1;
      wait_done(40, ok);
      chk("stall_done_seen", 32'(ok), 32'd1);
      @(negedge clk);
      check_run("stall", w0, a0, 4);

      // Zero-length burst
      a0 = addr_n; hv0 = hv_n;
      start(6'd5, 7'd0);
      @(negedge clk);
      chk("len0_done", 32'(bus.done), 32'd1);
      chk("len0_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      chk("len0_done_cleared", 32'(bus.done), 32'd0);
      chk("len0_busy_cleared", 32'(bus.busy), 32'd0);
      chk("len0_no_read", 32'(addr_n - a0), 32'd0);
      chk("len0_no_valid", 32'(hv_n - hv0), 32'd0);
`ifdef UNLOADER_CHECKSUM_EN
      chk("len0_csum", 32'(checksum), 32'd0);
`endif

      // rd_start while busy is ignored
      ram[10] = 8'hEE; ram[11] = 8'hFF;
      w0 = word_n; a0 = addr_n;
      start(6'd0, 7'd4);
      step();
      step();
      bus.rd_start = 1'b1;
      bus.rd_base = 6'd10;
      bus.rd_len = 7'd2;
      step();
      bus.rd_start = 1'b0;
      wait_done(40, ok);
      chk("busy_start_done_seen", 32'(ok), 32'd1);
      @(negedge clk);
      check_run("busy_start", w0, a0, 4);

      // Reset mid-burst, then a clean single-word burst
      w0 = word_n;
      start(6'd0, 7'd4);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (word_n - w0 >= 2) begin
            ok = 1'b1;
            break;
         end
      end
      chk("midrst_two_words", 32'(ok), 32'd1);
      d0 = done_n;
      #1 rst_n = 1'b0;
      #1 chk_reset_outputs("midrst");
      repeat (3) @(negedge clk);
      chk("midrst_no_done", 32'(done_n - d0), 32'd0);
      #1 rst_n = 1'b1;
      ew[0] = 8'h01;
      ea[0] = 6'd0;
      w0 = word_n; a0 = addr_n;
      start(6'd0, 7'd1);
      wait_done(20, ok);
      chk("after_rst_done_seen", 32'(ok), 32'd1);
      @(negedge clk);
      check_run("after_rst", w0, a0, 1);
`ifdef UNLOADER_CHECKSUM_EN
      chk("after_rst_csum", 32'(checksum), 32'h0001);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
